// File: rtl/mul_share_arbiter.sv
// Two-requester front end for a single shared sequential multiplier: round-robin grant,
// operand latching, start/done sequencing with a stale-done guard, and a timeout watchdog.
module mul_share_arbiter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned TIMEOUT = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0,
   input  logic               req1,
   input  logic [WIDTH-1:0]   a0,
   input  logic [WIDTH-1:0]   b0,
   input  logic [WIDTH-1:0]   a1,
   input  logic [WIDTH-1:0]   b1,
   output logic               done0,
   output logic               done1,
   output logic [2*WIDTH-1:0] result,
   output logic               err,
   output logic               busy,
   output logic               grant,
   output logic               mul_start,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic [2*WIDTH-1:0] mul_out,
   input  logic               mul_done
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StGuard,
      StWait,
      StResp
   } state_e;

   state_e             state_q;
   logic [WIDTH-1:0]   op_a_q;
   logic [WIDTH-1:0]   op_b_q;
   logic [TW-1:0]      timer_q;
   logic               last_q;
   logic               cool_q;
   logic               grant_q;
   logic               busy_q;
   logic               start_q;
   logic               done0_q;
   logic               done1_q;
   logic [2*WIDTH-1:0] result_q;
   logic               err_q;

   logic elig0;
   logic elig1;
   logic pick;

   // The requester served last is ignored for the first IDLE cycle after its response.
   always_comb begin
      elig0 = req0 && !(cool_q && !last_q);
      elig1 = req1 && !(cool_q && last_q);
      pick  = (elig0 && elig1) ? ~last_q : elig1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         op_a_q   <= '0;
         op_b_q   <= '0;
         timer_q  <= '0;
         last_q   <= 1'b1;
         cool_q   <= 1'b0;
         grant_q  <= 1'b0;
         busy_q   <= 1'b0;
         start_q  <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               cool_q <= 1'b0;
               if (elig0 || elig1) begin
                  grant_q <= pick;
                  op_a_q  <= pick ? a1 : a0;
                  op_b_q  <= pick ? b1 : b0;
                  busy_q  <= 1'b1;
                  start_q <= 1'b1;
                  state_q <= StStart;
               end
            end
            StStart: begin
               start_q <= 1'b0;
               state_q <= StGuard;
            end
            StGuard: begin
               // mul_done may still be high from the previous product here; ignore it.
               timer_q <= '0;
               state_q <= StWait;
            end
            StWait: begin
               if (mul_done) begin
                  result_q <= mul_out;
                  err_q    <= 1'b0;
                  done0_q  <= ~grant_q;
                  done1_q  <= grant_q;
                  state_q  <= StResp;
               end else if (timer_q == TW'(TIMEOUT - 1)) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
                  done0_q  <= ~grant_q;
                  done1_q  <= grant_q;
                  state_q  <= StResp;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            StResp: begin
               done0_q  <= 1'b0;
               done1_q  <= 1'b0;
               result_q <= '0;
               err_q    <= 1'b0;
               last_q   <= grant_q;
               cool_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign done0     = done0_q;
   assign done1     = done1_q;
   assign result    = result_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign grant     = grant_q;
   assign mul_start = start_q;
   assign mul_a     = op_a_q;
   assign mul_b     = op_b_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: stand-in sequential multiplier, per-cycle timeline model,
// directed cases with literal expectations, then randomized traffic.
module tb_mul_share_arbiter;

   localparam int W  = 8;
   localparam int TO = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst = 1'b1;
   logic           req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic           done0, done1, err, busy, grant, mul_start;
   logic [2*W-1:0] result;
   logic [W-1:0]   mul_a, mul_b;
   logic [2*W-1:0] mul_out = '0;
   logic           mul_done = 1'b0;

   mul_share_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .done0(done0), .done1(done1), .result(result), .err(err),
      .busy(busy), .grant(grant), .mul_start(mul_start),
      .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out), .mul_done(mul_done)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   // Stand-in multiplier: done stays high between operations and only drops one cycle
   // after start, so a stale done is visible during the guard cycle.
   int                    lat_cfg = 0;
   bit                    hang = 1'b0;
   int                    mcnt = 0;
   bit                    mpend = 1'b0;
   logic signed [2*W-1:0] sa = '0, sb = '0;

   always @(posedge clk) begin
      if (mul_start) begin
         mpend <= 1'b1;
         mcnt  <= lat_cfg;
         sa    <= {{W{mul_a[W-1]}}, mul_a};
         sb    <= {{W{mul_b[W-1]}}, mul_b};
      end else if (mpend) begin
         if (mcnt == 0) begin
            mpend <= 1'b0;
            if (!hang) begin
               mul_done <= 1'b1;
               mul_out  <= sa * sb;
            end else begin
               mul_done <= 1'b0;
            end
         end else begin
            mul_done <= 1'b0;
            mcnt     <= mcnt - 1;
         end
      end
   end

   // Timeline model: m_age counts cycles since the operation began (0 = start pulse cycle,
   // 1 = guard, 2.. = waiting); m_resp marks the single response cycle.
   bit             m_idle = 1'b1;
   bit             m_resp = 1'b0;
   int             m_age = 0;
   bit             m_grant = 1'b0;
   bit             m_last = 1'b1;
   bit             m_cool = 1'b0;
   logic [W-1:0]   m_a = '0, m_b = '0;
   logic [2*W-1:0] m_res = '0;
   bit             m_err = 1'b0;
   logic [2*W-1:0] m_prod = '0;
   int             n_ops = 0;

   always @(negedge clk) begin
      bit e0, e1;
      logic signed [2*W-1:0] xa, xb;
      chk("busy", 64'(busy), 64'(!m_idle));
      chk("mul_start", 64'(mul_start), 64'(!m_idle && !m_resp && m_age == 0));
      chk("done0", 64'(done0), 64'(m_resp && !m_grant));
      chk("done1", 64'(done1), 64'(m_resp && m_grant));
      chk("result", 64'(result), 64'(m_resp ? m_res : '0));
      chk("err", 64'(err), 64'(m_resp && m_err));
      if (!m_idle) begin
         chk("grant", 64'(grant), 64'(m_grant));
         chk("mul_a", 64'(mul_a), 64'(m_a));
         chk("mul_b", 64'(mul_b), 64'(m_b));
      end
      if (m_resp && !m_err) chk("product_arith", 64'(result), 64'(m_prod));

      if (rst) begin
         m_idle = 1'b1; m_resp = 1'b0; m_age = 0; m_grant = 1'b0; m_last = 1'b1;
         m_cool = 1'b0; m_a = '0; m_b = '0; m_res = '0; m_err = 1'b0;
      end else if (m_resp) begin
         m_resp = 1'b0; m_idle = 1'b1; m_last = m_grant; m_cool = 1'b1; n_ops++;
      end else if (m_idle) begin
         e0 = req0 && !(m_cool && !m_last);
         e1 = req1 && !(m_cool && m_last);
         m_cool = 1'b0;
         if (e0 || e1) begin
            m_grant = (e0 && e1) ? !m_last : e1;
            m_a = m_grant ? a1 : a0;
            m_b = m_grant ? b1 : b0;
            xa = {{W{m_a[W-1]}}, m_a};
            xb = {{W{m_b[W-1]}}, m_b};
            m_prod = xa * xb;
            m_idle = 1'b0;
            m_age = 0;
         end
      end else if (m_age >= 2 && mul_done) begin
         m_resp = 1'b1; m_res = mul_out; m_err = 1'b0;
      end else if (m_age >= 2 && m_age - 2 == TO - 1) begin
         m_resp = 1'b1; m_res = '0; m_err = 1'b1;
      end else begin
         m_age++;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // n counts negedges starting with the cycle in which the request is first presented.
   task automatic wait_done(output int n, output logic d1, output logic [2*W-1:0] r,
                            output logic e);
      bit got = 1'b0;
      n = 0; d1 = 1'b0; r = '0; e = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n++;
         if (done0 || done1) begin
            d1 = done1; r = result; e = err; got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL wait_done: no done pulse within 200 cycles");
      end
   endtask

   task automatic do_reset();
      cyc(); rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      cyc(); rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic d1, e;
      logic [2*W-1:0] r;

      cyc(); cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_grant", 64'(grant), 64'd0);
      chk("reset_start", 64'(mul_start), 64'd0);
      chk("reset_result", 64'(result), 64'd0);
      chk("reset_mul_a", 64'(mul_a), 64'd0);

      // 1: single request, minimum latency
      lat_cfg = 0;
      cyc(); req0 = 1'b1; a0 = 8'd10; b0 = 8'd5;
      wait_done(n, d1, r, e);
      chk("t1_latency", 64'(n), 64'd5);
      chk("t1_who", 64'(d1), 64'd0);
      chk("t1_result", 64'(r), 64'd50);
      chk("t1_err", 64'(e), 64'd0);
      cyc(); req0 = 1'b0;

      // 2: tie after reset goes to requester 0 first
      do_reset();
      cyc(); req0 = 1'b1; a0 = 8'hFD; b0 = 8'd7; req1 = 1'b1; a1 = 8'd4; b1 = 8'hFA;
      wait_done(n, d1, r, e);
      chk("t2_first_who", 64'(d1), 64'd0);
      chk("t2_first_result", 64'(r), 64'hFFEB);
      cyc(); req0 = 1'b0;
      wait_done(n, d1, r, e);
      chk("t2_second_who", 64'(d1), 64'd1);
      chk("t2_second_result", 64'(r), 64'hFFE8);
      cyc(); req1 = 1'b0;

      // 3: both held high, grants alternate
      do_reset();
      cyc(); req0 = 1'b1; a0 = 8'd2; b0 = 8'd3; req1 = 1'b1; a1 = 8'd5; b1 = 8'd7;
      for (int k = 0; k < 4; k++) begin
         wait_done(n, d1, r, e);
         chk("t3_alternate", 64'(d1), 64'(k % 2));
         chk("t3_result", 64'(r), (k % 2 == 1) ? 64'd35 : 64'd6);
      end
      cyc(); req0 = 1'b0; req1 = 1'b0;

      // Single requester held: one masked IDLE cycle between operations
      cyc(); req0 = 1'b1; a0 = 8'd3; b0 = 8'd3;
      wait_done(n, d1, r, e);
      wait_done(n, d1, r, e);
      chk("cooldown_gap", 64'(n), 64'd6);
      cyc(); req0 = 1'b0;
      cyc();

      // 4: multiplier never answers -> timeout abort
      hang = 1'b1;
      cyc(); req1 = 1'b1; a1 = 8'd3; b1 = 8'd3;
      wait_done(n, d1, r, e);
      chk("t4_latency", 64'(n), 64'(TO + 4));
      chk("t4_err", 64'(e), 64'd1);
      chk("t4_result", 64'(r), 64'd0);
      cyc(); req1 = 1'b0; hang = 1'b0;
      cyc();

      // done exactly at the timeout point is a normal completion
      lat_cfg = TO - 1;
      cyc(); req0 = 1'b1; a0 = 8'd7; b0 = 8'd9;
      wait_done(n, d1, r, e);
      chk("edge_latency", 64'(n), 64'(TO + 4));
      chk("edge_err", 64'(e), 64'd0);
      chk("edge_result", 64'(r), 64'd63);
      cyc(); req0 = 1'b0;
      cyc();

      // one cycle too late -> abort, done arrives afterwards and must be ignored
      lat_cfg = TO;
      cyc(); req1 = 1'b1; a1 = 8'd2; b1 = 8'd2;
      wait_done(n, d1, r, e);
      chk("late_err", 64'(e), 64'd1);
      cyc(); req1 = 1'b0;
      cyc(); cyc();

      // 5: reset during WAIT
      hang = 1'b1;
      cyc(); req0 = 1'b1; a0 = 8'd9; b0 = 8'd9;
      repeat (6) cyc();
      rst = 1'b1; req0 = 1'b0;
      cyc(); rst = 1'b0; hang = 1'b0;
      @(negedge clk);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_done", 64'({done0, done1}), 64'd0);
      chk("t5_result", 64'(result), 64'd0);
      chk("t5_err", 64'(err), 64'd0);
      chk("t5_start", 64'(mul_start), 64'd0);
      lat_cfg = 1;
      cyc(); req1 = 1'b1; a1 = 8'hF9; b1 = 8'hF9;
      wait_done(n, d1, r, e);
      chk("t5_result_after", 64'(r), 64'd49);
      cyc(); req1 = 1'b0;

      // 6: mul_done still high from the previous product across START/GUARD
      lat_cfg = 2;
      cyc(); req0 = 1'b1; a0 = 8'hFA; b0 = 8'd3;
      wait_done(n, d1, r, e);
      chk("t6_latency", 64'(n), 64'd7);
      chk("t6_result", 64'(r), 64'hFFEE);
      cyc(); req0 = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc();
         if ($urandom_range(0, 3) == 0) req0 = ~req0;
         if ($urandom_range(0, 3) == 0) req1 = ~req1;
         if ($urandom_range(0, 2) == 0) begin a0 = W'($urandom); b0 = W'($urandom); end
         if ($urandom_range(0, 2) == 0) begin a1 = W'($urandom); b1 = W'($urandom); end
         case ($urandom_range(0, 7))
            4: lat_cfg = TO - 2;
            5: lat_cfg = TO - 1;
            6: lat_cfg = TO;
            7: lat_cfg = TO + 1;
            default: lat_cfg = int'($urandom_range(0, 3));
         endcase
         hang = ($urandom_range(0, 19) == 0);
         rst  = ($urandom_range(0, 149) == 0);
      end
      cyc(); rst = 1'b0; req0 = 1'b0; req1 = 1'b0; hang = 1'b0;
      repeat (TO + 10) cyc();
      @(negedge clk);
      chk("final_idle", 64'(busy), 64'd0);
      chk("random_progress", 64'(n_ops > 100), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
